x_uart_loopback_buf: RTL

//  UART receive-to-transmit loopback with a parametrised byte FIFO and selectable drain policy.

---
 rtl/x_uart_loopback_buf.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/x_uart_loopback_buf.sv
// rtl/x_uart_loopback_buf.sv - UART loopback with byte FIFO, stream/burst drain and drop counting
// Contains the x_uart_rx / x_uart_tx helpers followed by the loopback top.

module x_uart_rx #(
    parameter int p_clk_hz = 12000000,
    parameter int p_baud   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] tdata,
    output logic       tvalid
);
    localparam int div = p_clk_hz / p_baud;
    localparam int cw  = $clog2(div + 1);
    localparam logic [cw-1:0] bit_last  = cw'(div - 1);
    localparam logic [cw-1:0] half_last = cw'(div / 2 - 1);

    typedef enum logic [1:0] {s_idle, s_start, s_data, s_stop} state_t;

    state_t        state;
    logic [cw-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [1:0]    sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= s_idle;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            sync   <= 2'b11;
            tdata  <= '0;
            tvalid <= 1'b0;
        end else begin
            sync   <= {sync[0], rx};
            tvalid <= 1'b0;
            case (state)
                s_idle: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!sync[1]) state <= s_start;
                end
                // Re-check the line at mid start bit to reject glitches.
                s_start: begin
                    if (cnt == half_last) begin
                        cnt   <= '0;
                        state <= sync[1] ? s_idle : s_data;
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                s_data: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        shift <= {sync[1], shift[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) state <= s_stop;
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                s_stop: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        state <= s_idle;
                        if (sync[1]) begin
                            tdata  <= shift;
                            tvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end
endmodule

module x_uart_tx #(
    parameter int p_clk_hz = 12000000,
    parameter int p_baud   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       tx
);
    localparam int div = p_clk_hz / p_baud;
    localparam int cw  = $clog2(div + 1);
    localparam logic [cw-1:0] bit_last = cw'(div - 1);

    typedef enum logic [1:0] {s_idle, s_start, s_data, s_stop} state_t;

    state_t        state;
    logic [cw-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    assign tready = (state == s_idle) && tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= s_idle;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                s_idle: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (tvalid) begin
                        shift <= tdata;
                        tx    <= 1'b0;
                        state <= s_start;
                    end
                end
                s_start: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                        state <= s_data;
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                s_data: begin
                    if (cnt == bit_last) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= s_stop;
                        end else begin
                            tx    <= shift[0];
                            shift <= {1'b0, shift[7:1]};
                            idx   <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                s_stop: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        state <= s_idle;
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end
endmodule

module x_uart_loopback_buf #(
    parameter int p_clk_hz = 12000000,
    parameter int p_baud   = 115200,
    parameter int p_depth  = 128,
    parameter int p_hi     = p_depth - 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx,
    output logic                       o_tx,
    input  logic                       i_mode,
    input  logic                       i_hold,
    output logic [$clog2(p_depth):0]   o_fill,
    output logic                       o_overflow,
    output logic [7:0]                 o_drop_cnt
);
    localparam int aw = $clog2(p_depth);
    localparam int fw = aw + 1;
    localparam logic [fw-1:0] depth_v = fw'(p_depth);
    localparam logic [fw-1:0] hi_v    = fw'(p_hi);

    typedef enum logic {s_idle, s_drain} state_t;

    logic [7:0]    mem [p_depth];
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [fw-1:0] fill;
    logic [fw-1:0] fill_next;
    state_t        state;

    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    x_uart_rx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_rx (
        .clk    (i_clk),
        .rst    (i_rst),
        .rx     (i_rx),
        .tdata  (rx_tdata),
        .tvalid (rx_tvalid)
    );

    x_uart_tx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_tx (
        .clk    (i_clk),
        .rst    (i_rst),
        .tdata  (tx_tdata),
        .tvalid (tx_tvalid),
        .tready (tx_tready),
        .tx     (o_tx)
    );

    // A byte arriving while full is dropped even if a pop frees a slot this cycle.
    assign full      = (fill == depth_v);
    assign empty     = (fill == '0);
    assign push      = rx_tvalid && !full;
    assign pop       = tx_tready;
    assign tx_tvalid = (state == s_drain) && !empty && !i_hold;
    assign tx_tdata  = mem[rd_ptr];
    assign o_fill    = fill;

    always_comb begin
        fill_next = fill;
        if (push && !pop) begin
            fill_next = fill + fw'(1);
        end else if (!push && pop) begin
            fill_next = fill - fw'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= rx_tdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            state      <= s_idle;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + aw'(1);
            if (pop)  rd_ptr <= rd_ptr + aw'(1);
            fill <= fill_next;
            if (rx_tvalid && full) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 8'hff) o_drop_cnt <= o_drop_cnt + 8'd1;
            end
            // i_mode only matters for leaving IDLE; a drain always runs to empty.
            case (state)
                s_idle: begin
                    if (!i_hold && ((!i_mode && !empty) || (i_mode && fill >= hi_v)))
                        state <= s_drain;
                end
                s_drain: begin
                    if (fill_next == '0) state <= s_idle;
                end
                default: state <= s_idle;
            endcase
        end
    end
endmodule
